// File: rtl/fetch_unit.sv
// Instruction fetch stage: one word per cycle into a handshaked IR, with
// jumps resolved internally after the pipeline drains, and a sticky halt.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] ir,
    output logic [15:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        pipe_empty,
    output logic [2:0]  jmp_sel,
    input  logic        jmp_zero,
    output logic        halted
);

    typedef enum logic [1:0] {RUN, JWAIT, HALT} state_t;

    localparam logic [2:0] OP_JUMP = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b011;

    state_t      state, state_n;
    logic [15:0] pc, pc_n;
    logic [15:0] ir_n, ir_pc_n;
    logic        ir_valid_n;
    logic [12:0] jword, jword_n;
    logic [15:0] jump_pc, jump_pc_n;
    logic        slot_free;
    logic [15:0] offset_ext;

    assign slot_free  = !ir_valid || ir_ready;
    assign offset_ext = {{6{jword[9]}}, jword[9:0]};

    // NOTE: every next-state variable takes its current value first, so no
    // path through the case below can leave one unassigned and infer a latch.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        ir_n       = ir;
        ir_pc_n    = ir_pc;
        ir_valid_n = ir_valid;
        jword_n    = jword;
        jump_pc_n  = jump_pc;

        case (state)
            RUN: begin
                if (slot_free) begin
                    if (imem_data[15:13] == OP_JUMP) begin
                        // Jumps never reach ir; a free slot with ir_ready=0 is already empty.
                        jword_n   = imem_data[12:0];
                        jump_pc_n = pc;
                        state_n   = JWAIT;
                        if (ir_ready) ir_valid_n = 1'b0;
                    end else begin
                        ir_n       = imem_data;
                        ir_pc_n    = pc;
                        ir_valid_n = 1'b1;
                        if (imem_data[15:13] == OP_HALT) state_n = HALT;
                        else                             pc_n    = pc + 16'd1;
                    end
                end
            end
            JWAIT: begin
                if (!ir_valid && pipe_empty) begin
                    pc_n    = jmp_zero ? (jump_pc + offset_ext) : (jump_pc + 16'd1);
                    state_n = RUN;
                end else if (ir_ready) begin
                    ir_valid_n = 1'b0;
                end
            end
            HALT: begin
                if (ir_ready) ir_valid_n = 1'b0;
            end
            default: state_n = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            pc       <= RESET_PC;
            ir       <= 16'h0000;
            ir_pc    <= 16'h0000;
            ir_valid <= 1'b0;
            jword    <= '0;
            jump_pc  <= 16'h0000;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            ir       <= ir_n;
            ir_pc    <= ir_pc_n;
            ir_valid <= ir_valid_n;
            jword    <= jword_n;
            jump_pc  <= jump_pc_n;
        end
    end

    assign imem_addr = pc;
    assign halted    = (state == HALT);
    assign jmp_sel   = (state == JWAIT) ? jword[12:10] : 3'b000;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: table of jump vectors, hand-written multi-cycle
// sequences, and a queue scoreboard fed by an architectural program model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] imem_addr, imem_data;
    logic [15:0] ir, ir_pc;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic        pipe_empty = 1'b1;
    logic [2:0]  jmp_sel;
    logic        jmp_zero;
    logic        halted;

    logic [15:0] mem  [0:65535];
    logic [15:0] regs [0:7];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];
    assign jmp_zero  = (regs[jmp_sel] == 16'h0000);

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .ir         (ir),
        .ir_pc      (ir_pc),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .pipe_empty (pipe_empty),
        .jmp_sel    (jmp_sel),
        .jmp_zero   (jmp_zero),
        .halted     (halted)
    );

    typedef struct {
        string       name;
        logic [15:0] at;
        logic [15:0] word;
        bit          zero;
        logic [15:0] exp_pc;
        logic [2:0]  exp_sel;
    } vec_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] word;
    } item_t;

    item_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
        for (int r = 0; r < 8; r++) regs[r] = 16'h0000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Bench ISA: 001 ldi rd,#imm8; 010 dec rd; everything else leaves registers alone.
    function automatic logic [15:0] exec_value(input logic [15:0] w, input logic [15:0] cur);
        case (w[15:13])
            3'b001:  return {8'h00, w[7:0]};
            3'b010:  return cur - 16'd1;
            default: return cur;
        endcase
    endfunction

    task automatic build_expected(output logic [15:0] last_pc);
        logic [15:0] m_regs [0:7];
        logic [15:0] pc, w, off;
        for (int r = 0; r < 8; r++) m_regs[r] = 16'h0000;
        pc = 16'h0000;
        last_pc = pc;
        q.delete();
        for (int n = 0; n < 2000; n++) begin
            w = mem[pc];
            if (w[15:13] == 3'b110) begin
                off = {{6{w[9]}}, w[9:0]};
                pc  = (m_regs[w[12:10]] == 16'h0000) ? pc + off : pc + 16'd1;
            end else begin
                q.push_back('{pc, w});
                m_regs[w[12:10]] = exec_value(w, m_regs[w[12:10]]);
                last_pc = pc;
                if (w[15:13] == 3'b011) break;
                pc = pc + 16'd1;
            end
        end
    endtask

    task automatic run_sb(input string name, input int budget, input int exp_outs);
        logic [15:0] last_pc;
        item_t       e;
        int          outs;
        bit          done;
        outs = 0;
        done = 1'b0;
        build_expected(last_pc);
        pipe_empty = 1'b1;
        ir_ready   = 1'b1;
        do_reset();
        for (int c = 0; c < budget && !done; c++) begin
            step();
            ir_ready = ($urandom_range(0, 3) != 0);
            if (ir_valid && ir_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL %s_extra: got ir_pc %0h expected no more issues", name, ir_pc);
                end else begin
                    e = q.pop_front();
                    check({name, "_pc"}, {16'h0, ir_pc}, {16'h0, e.pc});
                    check({name, "_ir"}, {16'h0, ir}, {16'h0, e.word});
                end
                if (ir == 16'h8400) outs++;
                regs[ir[12:10]] = exec_value(ir, regs[ir[12:10]]);
            end
            if (q.size() == 0 && halted) done = 1'b1;
        end
        check({name, "_finished"}, {31'h0, done}, 32'h1);
        check({name, "_halted"}, {31'h0, halted}, 32'h1);
        check({name, "_final_pc"}, {16'h0, imem_addr}, {16'h0, last_pc});
        if (exp_outs >= 0) check({name, "_outs"}, outs, exp_outs);
        ir_ready = 1'b1;
    endtask

    task automatic drain_test(input bit reset_mid);
        clear_all();
        mem[0] = 16'h240A;              // ldi r1,#10
        mem[1] = 16'hCC05;              // jump r3,+5
        mem[6] = 16'h8006;
        pipe_empty = 1'b0;
        ir_ready   = 1'b1;
        do_reset();
        step();
        check("drain_first", {16'h0, ir_pc}, 32'h0);
        step();
        check("drain_jump_not_issued", {31'h0, ir_valid}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("drain_pc_hold", {16'h0, imem_addr}, 32'h1);
            check("drain_sel", {29'h0, jmp_sel}, 32'h3);
        end
        if (reset_mid) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
            check("rst_jwait_pc", {16'h0, imem_addr}, 32'h0);
            check("rst_jwait_valid", {31'h0, ir_valid}, 32'h0);
            check("rst_jwait_halted", {31'h0, halted}, 32'h0);
            check("rst_jwait_sel", {29'h0, jmp_sel}, 32'h0);
            step();
            check("rst_jwait_refetch", {15'h0, ir_valid, ir_pc}, 32'h1_0000);
        end else begin
            pipe_empty = 1'b1;
            step();
            check("drain_resolved_pc", {16'h0, imem_addr}, 32'h6);
            step();
            check("drain_target", {ir, ir_pc}, 32'h8006_0006);
        end
        pipe_empty = 1'b1;
    endtask

    initial begin
        vec_t        vecs [7];
        logic [15:0] at;
        logic [2:0]  seen_sel;
        bit          got;

        vecs[0] = '{"jmp_not_taken",   16'h0005, 16'hC402, 1'b0, 16'h0006, 3'd1};
        vecs[1] = '{"jmp_back_taken",  16'h0006, 16'hC3FD, 1'b1, 16'h0003, 3'd0};
        vecs[2] = '{"jmp_wrap_below",  16'h0001, 16'hCBFD, 1'b1, 16'hFFFE, 3'd2};
        vecs[3] = '{"jmp_wrap_above",  16'hFFFF, 16'hCC02, 1'b1, 16'h0001, 3'd3};
        vecs[4] = '{"jmp_max_fwd",     16'h01FF, 16'hD1FF, 1'b1, 16'h03FE, 3'd4};
        vecs[5] = '{"jmp_max_back",    16'hFE00, 16'hD600, 1'b1, 16'hFC00, 3'd5};
        vecs[6] = '{"jmp_at_zero_nt",  16'h0000, 16'hD807, 1'b0, 16'h0001, 3'd6};

        clear_all();
        step();
        check("reset_pc", {16'h0, imem_addr}, 32'h0);
        check("reset_ir", {ir, ir_pc}, 32'h0);
        check("reset_valid", {31'h0, ir_valid}, 32'h0);
        check("reset_halted", {31'h0, halted}, 32'h0);
        check("reset_sel", {29'h0, jmp_sel}, 32'h0);

        // Each vector reaches its jump through a taken r0 jump from address 0.
        for (int i = 0; i < 7; i++) begin
            clear_all();
            at = vecs[i].at;
            if (at != 16'h0000) mem[0] = {3'b110, 3'b000, at[9:0]};
            mem[at] = vecs[i].word;
            mem[vecs[i].exp_pc] = 16'h8000 + 16'(i);
            if (!vecs[i].zero) regs[vecs[i].exp_sel] = 16'h0055;
            ir_ready   = 1'b1;
            pipe_empty = 1'b1;
            do_reset();
            seen_sel = 3'b000;
            got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                step();
                if (imem_addr == at) seen_sel = jmp_sel;
                if (ir_valid) got = 1'b1;
            end
            check({vecs[i].name, "_issued"}, {31'h0, got}, 32'h1);
            check({vecs[i].name, "_pc"}, {16'h0, ir_pc}, {16'h0, vecs[i].exp_pc});
            check({vecs[i].name, "_ir"}, {16'h0, ir}, {16'h0, 16'h8000 + 16'(i)});
            check({vecs[i].name, "_sel"}, {29'h0, seen_sel}, {29'h0, vecs[i].exp_sel});
        end

        // Straight line into halt, then reset out of HALT.
        clear_all();
        mem[0] = 16'h240A;
        mem[1] = 16'h2801;
        mem[2] = 16'h6000;
        ir_ready = 1'b1;
        do_reset();
        step();
        check("line_0", {ir, ir_pc}, 32'h240A_0000);
        step();
        check("line_1", {ir, ir_pc}, 32'h2801_0001);
        step();
        check("line_2", {ir, ir_pc}, 32'h6000_0002);
        check("line_halted", {31'h0, halted}, 32'h1);
        step();
        check("halt_drained", {31'h0, ir_valid}, 32'h0);
        check("halt_pc_frozen", {16'h0, imem_addr}, 32'h2);
        check("halt_sticky", {31'h0, halted}, 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_halt_pc", {16'h0, imem_addr}, 32'h0);
        check("rst_halt_flags", {30'h0, halted, ir_valid}, 32'h0);
        step();
        check("rst_halt_refetch", {ir, ir_pc}, 32'h240A_0000);

        // Backpressure after the first load.
        do_reset();
        step();
        ir_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_hold_ir", {ir, ir_pc}, 32'h240A_0000);
            check("bp_hold_pc", {15'h0, ir_valid, imem_addr}, 32'h1_0001);
        end
        ir_ready = 1'b1;
        step();
        check("bp_resume", {ir, ir_pc}, 32'h2801_0001);

        drain_test(1'b0);
        drain_test(1'b1);

        // A taken zero-offset jump spins on itself forever.
        clear_all();
        mem[0] = 16'hC000;
        do_reset();
        for (int k = 0; k < 8; k++) step();
        check("spin_pc", {16'h0, imem_addr}, 32'h0);
        check("spin_flags", {30'h0, halted, ir_valid}, 32'h0);

        // Countdown 10..0 with random backpressure.
        clear_all();
        mem[0] = 16'h240A;              // ldi r1,#10
        mem[3] = 16'h8400;              // out r1
        mem[4] = 16'hC403;              // jump r1,+3
        mem[5] = 16'h4400;              // dec r1
        mem[6] = 16'hC3FD;              // jump r0,-3
        mem[8] = 16'h6000;              // halt
        run_sb("countdown", 800, 11);

        // Jump landing on a jump landing on a halt.
        clear_all();
        mem[0] = 16'hC002;
        mem[2] = 16'hC003;
        mem[5] = 16'h6000;
        run_sb("chain", 100, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter RESET_PC, default 16'h0000, SHALL set the PC value loaded on reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_addr  output  16  instruction memory address; equals pc combinationally.
REQ-006 imem_data  input  16  combinational instruction word at imem_addr; unmapped addresses return 16'h0000 (NOP).
REQ-007 ir  output  16  registered instruction presented downstream.
REQ-008 ir_pc  output  16  address from which ir was fetched.
REQ-009 ir_valid  output  1  ir holds an instruction not yet accepted.
REQ-010 ir_ready  input  1  downstream accepts ir this cycle when ir_valid=1.
REQ-011 pipe_empty  input  1  all previously accepted instructions have completed register writeback.
REQ-012 jmp_sel  output  3  register index tested by a pending jump; equals jump word bits [12:10].
REQ-013 jmp_zero  input  1  register jmp_sel currently equals 16'h0000.
REQ-014 halted  output  1  fetch permanently stopped until reset.

Function
REQ-015 The opcode SHALL be imem_data[15:13]; 3'b110 is jump, 3'b011 is halt, and all other opcodes are ordinary.
REQ-016 The block SHALL implement states RUN, JWAIT and HALT.
REQ-017 The IR SHALL load when (ir_valid=0 or ir_ready=1) in RUN; this condition is termed "slot free".
REQ-018 RUN, slot free, ordinary opcode: ir<=imem_data, ir_pc<=pc, ir_valid<=1, pc<=pc+1.
REQ-019 RUN, slot free, halt: ir<=imem_data, ir_pc<=pc, ir_valid<=1, pc unchanged, state<=HALT.
REQ-020 RUN, slot free, jump: the jump SHALL NOT be issued to ir; jump word latched internally, jump_pc<=pc, state<=JWAIT; ir_valid<=0 if ir_ready=1, else ir_valid held.
REQ-021 RUN, slot not free: ir, ir_pc, ir_valid and pc SHALL hold.
REQ-022 JWAIT: the block SHALL resolve the jump only in a cycle with ir_valid=0 and pipe_empty=1; otherwise it holds, with ir_valid cleared on ir_ready=1.
REQ-023 Jump resolution: if jmp_zero=1, pc<=jump_pc+sign_extend(offset[9:0]) modulo 2^16; else pc<=jump_pc+1; state<=RUN.
REQ-024 The offset SHALL be 10-bit two's complement (range -512..+511); offset 0 taken SHALL re-fetch the same jump indefinitely.
REQ-025 PC arithmetic SHALL wrap: 16'hFFFF+1=16'h0000; 16'h0001+(-3)=16'hFFFE.
REQ-026 jmp_sel SHALL be driven from the latched jump word during JWAIT and equal 3'b000 otherwise.
REQ-027 HALT: pc SHALL be frozen and no further fetch SHALL occur; ir drains normally on ir_ready; halted=1.
REQ-028 halted SHALL be 1 exactly when state=HALT.
REQ-029 Taking a jump to a halt or another jump SHALL follow REQ-019/REQ-020 with no special case.
REQ-030 Fetch throughput SHALL be one instruction per cycle in RUN with ir_ready held high; jump cost is at least 2 cycles.

Reset
REQ-031 On reset=1 at a clock edge: pc<=RESET_PC, ir<=16'h0000, ir_pc<=16'h0000, ir_valid<=0, state<=RUN, halted<=0, latched jump word cleared.
REQ-032 Reset SHALL override all other events in that cycle, including mid-JWAIT or HALT.
REQ-033 First fetch SHALL occur on the first edge after reset deasserts.

Verification
REQ-034 Straight line: memory {0:ldi r1,#10; 1:ldi r2,#1; 2:halt}, ir_ready=1 -> ir_pc 0,1,2 on consecutive cycles; halted=1 after the third load; pc frozen at 2.
REQ-035 Backpressure: ir_ready=0 for 3 cycles after the first load -> ir=word@0 held and pc=1 held; on release, resumes with word@1.
REQ-036 Jump not taken: word@5=16'b110_001_0000000010, jmp_zero=0, pipe_empty=1 -> jump never appears on ir; next ir_pc=6; jmp_sel=3'b001 during JWAIT.
REQ-037 Jump backward taken: word@6=16'b110_000_1111111101, jmp_zero=1 -> next ir_pc=3; countdown program {10..0} outputs r1 eleven times, then halts at address 8.
REQ-038 Drain wait: jump fetched with pipe_empty=0 for 4 cycles -> pc unchanged until pipe_empty=1, then resolves on that edge.
REQ-039 Reset mid-JWAIT and in HALT -> next cycle pc=RESET_PC, ir_valid=0, halted=0, fetch restarts at RESET_PC.
